// File: rtl/retospect_neuro_pkg.sv
`default_nettype none
// ============================================================================
// Module   : retospect_neuro_pkg
// Purpose  : Shared types, clockbus indices and saturation helper for the
//            neuron compute core and its sub-blocks.
// Revision : 1.0 - initial release
// ============================================================================
package retospect_neuro_pkg;

    // Neuron control state: integrating inputs, or ignoring them after a fire
    typedef enum logic [0:0] {
        ST_INTEG  = 1'b0,
        ST_REFRAC = 1'b1
    } state_t;

    // Fixed clockbus lanes: lane 0 never ticks, lane 1 ticks every cycle
    localparam int CLK_NEVER  = 0;
    localparam int CLK_ALWAYS = 1;

    // Clamp a wide signed value into the range of a WIDTH-bit signed number
    function automatic int saturate(input int val, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/retospect_weight_sum.sv
`default_nettype none
// ============================================================================
// Module   : retospect_weight_sum
// Purpose  : Combinational gated signed sum of N_IN weights; weight i is added
//            only when spike_in[i] is set. Result is full width, never wraps.
// Revision : 1.0 - initial release
// ============================================================================
module retospect_weight_sum #(
    parameter int N_IN    = 4,
    parameter int W_WIDTH = 3,
    parameter int SUM_W   = W_WIDTH + $clog2(N_IN)
) (
    input  logic [N_IN-1:0]         spike_in,
    input  logic [N_IN*W_WIDTH-1:0] weights,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [SUM_W-1:0] term [N_IN];

    // Sign-extend each weight to the sum width and gate it by its spike bit
    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_term
            assign term[gi] = spike_in[gi]
                            ? SUM_W'($signed(weights[gi*W_WIDTH +: W_WIDTH]))
                            : '0;
        end
    endgenerate

    // Accumulate the gated terms
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            sum = sum + term[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/retospect_lif_neuron.sv
`default_nettype none
// ============================================================================
// Module   : retospect_lif_neuron
// Purpose  : Leaky integrate-and-fire neuron for one fabric cell. Integrates
//            weighted neighbour spikes into a saturating signed potential,
//            leaks toward zero on a selected clockbus tick, fires a one-cycle
//            pulse at threshold and then ignores inputs for REFRACT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module retospect_lif_neuron
    import retospect_neuro_pkg::*;
#(
    parameter int N_IN           = 4,
    parameter int W_WIDTH        = 3,
    parameter int UT_WIDTH       = 4,
    parameter int V_WIDTH        = 6,
    parameter int REFRACT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reset_nn,
    input  logic                      config_en,
    input  logic [N_IN-1:0]           spike_in,
    input  logic [N_IN*W_WIDTH-1:0]   weights,
    input  logic [UT_WIDTH-1:0]       u_t,
    input  logic [2:0]                decay_sel,
    input  logic [7:0]                clockbus,
    output logic                      spike_out,
    output logic [V_WIDTH-1:0]        v_out
);

    localparam int SUM_W  = W_WIDTH + $clog2(N_IN);
    localparam int WIDE_W = V_WIDTH + 2;
    // Keep the counter at least one bit wide even with no refractory period
    localparam int RC_W   = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

    localparam logic signed [V_WIDTH-1:0] V_ONE  = V_WIDTH'(1);
    localparam logic [RC_W-1:0]           RC_ONE = RC_W'(1);
    localparam logic [RC_W-1:0]           RC_INIT = RC_W'(REFRACT_CYCLES);

    logic signed [V_WIDTH-1:0] v;
    state_t                    state;
    logic [RC_W-1:0]           rcnt;

    logic                      tick;
    logic signed [V_WIDTH-1:0] v_d;
    logic signed [SUM_W-1:0]   sum;
    logic signed [WIDE_W-1:0]  v_wide;
    logic signed [V_WIDTH-1:0] v_int;
    logic signed [WIDE_W-1:0]  u_t_ext;
    logic                      fire;

    assign v_out = v;
    assign tick  = clockbus[decay_sel];

    retospect_weight_sum #(
        .N_IN    (N_IN),
        .W_WIDTH (W_WIDTH),
        .SUM_W   (SUM_W)
    ) u_weight_sum (
        .spike_in (spike_in),
        .weights  (weights),
        .sum      (sum)
    );

    // Leak one step toward zero when the selected tick is active
    always_comb begin
        v_d = v;
        if (tick) begin
            if (v[V_WIDTH-1]) begin
                v_d = v + V_ONE;
            end else if (v != '0) begin
                v_d = v - V_ONE;
            end
        end
    end

    // Add the gated weight sum in a widened domain, clamp, then test threshold
    always_comb begin
        v_wide  = WIDE_W'(v_d) + WIDE_W'(sum);
        v_int   = V_WIDTH'(saturate(int'(v_wide), V_WIDTH));
        u_t_ext = $signed(WIDE_W'({1'b0, u_t}));
        fire    = (WIDE_W'(v_int) >= u_t_ext);
    end

    // Membrane, fire pulse and refractory control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v         <= '0;
            spike_out <= 1'b0;
            state     <= ST_INTEG;
            rcnt      <= '0;
        end else if (reset_nn) begin
            v         <= '0;
            spike_out <= 1'b0;
            state     <= ST_INTEG;
            rcnt      <= '0;
        end else if (config_en) begin
            spike_out <= 1'b0;
        end else begin
            case (state)
                ST_INTEG: begin
                    if (fire) begin
                        v         <= '0;
                        spike_out <= 1'b1;
                        if (REFRACT_CYCLES > 0) begin
                            state <= ST_REFRAC;
                            rcnt  <= RC_INIT;
                        end
                    end else begin
                        v         <= v_int;
                        spike_out <= 1'b0;
                    end
                end
                ST_REFRAC: begin
                    v         <= '0;
                    spike_out <= 1'b0;
                    rcnt      <= rcnt - RC_ONE;
                    if (rcnt == RC_ONE) begin
                        state <= ST_INTEG;
                    end
                end
                default: begin
                    v         <= '0;
                    spike_out <= 1'b0;
                    state     <= ST_INTEG;
                    rcnt      <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_retospect_lif_neuron.sv
`default_nettype none
// ============================================================================
// Module   : tb_retospect_lif_neuron
// Purpose  : Directed self-checking bench for retospect_lif_neuron.
// Revision : 1.0 - initial release
// ============================================================================
module tb_retospect_lif_neuron;

    logic        clk;
    logic        reset;
    logic        reset_nn;
    logic        config_en;
    logic [3:0]  spike_in;
    logic [11:0] weights;
    logic [3:0]  u_t;
    logic [2:0]  decay_sel;
    logic [7:0]  clockbus;
    logic        spike_out;
    logic [5:0]  v_out;

    int n_tests;
    int n_fail;

    retospect_lif_neuron #(
        .N_IN           (4),
        .W_WIDTH        (3),
        .UT_WIDTH       (4),
        .V_WIDTH        (6),
        .REFRACT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reset_nn  (reset_nn),
        .config_en (config_en),
        .spike_in  (spike_in),
        .weights   (weights),
        .u_t       (u_t),
        .decay_sel (decay_sel),
        .clockbus  (clockbus),
        .spike_out (spike_out),
        .v_out     (v_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Potential as a signed integer
    function automatic int vs();
        return int'($signed(v_out));
    endfunction

    // Advance one clock edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic net_reset();
        reset_nn = 1'b1;
        step();
        reset_nn = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        reset_nn  = 1'b0;
        config_en = 1'b0;
        spike_in  = 4'b0000;
        weights   = 12'b011_011_011_011;
        u_t       = 4'd5;
        decay_sel = 3'd0;
        clockbus  = 8'b0000_0010;

        #3;
        chk("reset_v", vs(), 0);
        chk("reset_spk", int'(spike_out), 0);
        step();
        reset = 1'b0;

        // Basic fire: w=+3, u_t=5, input 0 held
        spike_in = 4'b0001;
        step(); chk("fire_e1_v", vs(), 3);   chk("fire_e1_spk", int'(spike_out), 0);
        step(); chk("fire_e2_v", vs(), 0);   chk("fire_e2_spk", int'(spike_out), 1);
        step(); chk("fire_e3_v", vs(), 0);   chk("fire_e3_spk", int'(spike_out), 0);
        step(); chk("fire_e4_v", vs(), 0);
        step(); chk("fire_e5_v", vs(), 3);

        // reset_nn aborts refractory: next edge integrates
        step(); chk("abort_fire_spk", int'(spike_out), 1);
        net_reset();
        chk("abort_nn_v", vs(), 0);
        step(); chk("abort_resume_v", vs(), 3);

        // Leak: one spike of +3, then leak every cycle
        net_reset();
        weights   = 12'b000_000_000_011;
        u_t       = 4'd15;
        decay_sel = 3'd1;
        spike_in  = 4'b0001;
        step(); chk("leak_v0", vs(), 3);
        spike_in = 4'b0000;
        step(); chk("leak_v1", vs(), 2);
        step(); chk("leak_v2", vs(), 1);
        step(); chk("leak_v3", vs(), 0);
        step(); chk("leak_v4", vs(), 0);
        chk("leak_nofire", int'(spike_out), 0);

        // Saturation at the negative rail, then leak back up
        net_reset();
        weights   = 12'b100_100_100_100;
        spike_in  = 4'b1111;
        decay_sel = 3'd0;
        step(); chk("sat_v0", vs(), -16);
        step(); chk("sat_v1", vs(), -32);
        step(); chk("sat_v2", vs(), -32);
        spike_in  = 4'b0000;
        decay_sel = 3'd1;
        step(); chk("sat_leak0", vs(), -31);
        step(); chk("sat_leak1", vs(), -30);

        // Always-fire with u_t=0: pulse every third edge
        decay_sel = 3'd0;
        u_t       = 4'd0;
        net_reset();
        chk("af_nn_spk", int'(spike_out), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("af_spk%0d", i), int'(spike_out), (i % 3 == 0) ? 1 : 0);
        end

        // Freeze with config_en at v=4
        net_reset();
        weights  = 12'b000_000_000_010;
        u_t      = 4'd15;
        spike_in = 4'b0001;
        step(); chk("frz_pre0", vs(), 2);
        step(); chk("frz_pre1", vs(), 4);
        config_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("frz_v%0d", i), vs(), 4);
            chk($sformatf("frz_spk%0d", i), int'(spike_out), 0);
        end
        config_en = 1'b0;
        step(); chk("frz_resume", vs(), 6);

        // Asynchronous reset during refractory
        net_reset();
        weights = 12'b000_000_000_011;
        u_t     = 4'd5;
        step(); chk("ar_pre_v", vs(), 3);
        step(); chk("ar_fire_spk", int'(spike_out), 1);
        reset = 1'b1;
        #1;
        chk("ar_async_v", vs(), 0);
        chk("ar_async_spk", int'(spike_out), 0);
        #1;
        reset = 1'b0;
        step(); chk("ar_integ_v", vs(), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
